// File: rtl/cpu_dbg_pkg.sv
// cpu_dbg_pkg: shared types for the CPU debug controller.
//   cmd_op_e : host command opcodes (codes 6 and 7 are reserved and ignored)
//   cause_e  : last halt reason reported on the cause port
//   state_e  : controller FSM states
//   idx_w()  : breakpoint index width, never less than 1 bit
package cpu_dbg_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_RUN    = 3'd1,
    OP_STEP   = 3'd2,
    OP_HALT   = 3'd3,
    OP_SET_BP = 3'd4,
    OP_CLR_BP = 3'd5
  } cmd_op_e;

  // STEP and HOST share one code; host_flag inside the controller tells them apart.
  typedef enum logic [1:0] {
    CAUSE_RESET      = 2'd0,
    CAUSE_HALT_INSTR = 2'd1,
    CAUSE_BREAK      = 2'd2,
    CAUSE_STEP_HOST  = 2'd3
  } cause_e;

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_dbg_ctrl_bp_match.sv
// bp_match: parallel compare of pc against all breakpoint addresses, with a
// lowest-index priority encoder over the valid matches.
//   pc_i       : program counter to compare
//   bp_addr_i  : breakpoint addresses, one per slot
//   bp_valid_i : per-slot valid bits
//   hit_o      : at least one valid slot matches
//   idx_o      : lowest matching slot index (0 when no hit)
module bp_match #(
  parameter int PC_W   = 16,
  parameter int NUM_BP = 4,
  parameter int IDX_W  = 2
) (
  input  logic [PC_W-1:0]              pc_i,
  input  logic [NUM_BP-1:0][PC_W-1:0]  bp_addr_i,
  input  logic [NUM_BP-1:0]            bp_valid_i,
  output logic                         hit_o,
  output logic [IDX_W-1:0]             idx_o
);

  // Scan from the top down so the lowest matching index is the last written.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_valid_i[i] && (bp_addr_i[i] == pc_i)) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/cpu_dbg_ctrl.sv
// cpu_dbg_ctrl: run/step/halt debug controller with hardware breakpoints.
//   CLK_50      : clock, rising edge
//   KEY0        : asynchronous active-low reset
//   pc          : next-PC, valid while retire is high
//   retire      : one-cycle instruction completion pulse
//   halt_instr  : retiring instruction is HALT
//   cmd_*       : host command channel (cmd_ready is always high)
//   cpu_en      : CPU advance enable (registered)
//   halted      : controller is in HALTED (registered)
//   cause       : last halt reason, bp_idx: breakpoint that caused BREAK
//   retired_cnt : instructions retired while enabled, wraps
//
// state     | meaning
// HALTED    | CPU stopped; accepts RUN, STEP, SET_BP, CLR_BP
// RUN       | CPU free-running until a stop condition or host HALT
// STEP      | CPU runs until step_left retires complete or another stop
module cpu_dbg_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int PC_W   = 16,
  parameter int NUM_BP = 4,
  parameter int CNT_W  = 32,
  localparam int IDX_W = idx_w(NUM_BP)
) (
  input  logic              CLK_50,
  input  logic              KEY0,
  input  logic [PC_W-1:0]   pc,
  input  logic              retire,
  input  logic              halt_instr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [PC_W-1:0]   cmd_arg,
  input  logic [IDX_W-1:0]  cmd_idx,
  output logic              cpu_en,
  output logic              halted,
  output logic [1:0]        cause,
  output logic [IDX_W-1:0]  bp_idx,
  output logic [CNT_W-1:0]  retired_cnt
);

  state_e                     state_q, state_d;
  logic                       cpu_en_q, cpu_en_d;
  logic                       halted_q, halted_d;
  cause_e                     cause_q, cause_d;
  logic                       host_flag_q, host_flag_d;
  logic [IDX_W-1:0]           bp_idx_q, bp_idx_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [PC_W-1:0]            step_left_q, step_left_d;
  logic [NUM_BP-1:0][PC_W-1:0] bp_addr_q, bp_addr_d;
  logic [NUM_BP-1:0]          bp_valid_q, bp_valid_d;

  logic                       bp_hit;
  logic [IDX_W-1:0]           bp_hit_idx;
  logic                       stop;

  bp_match #(
    .PC_W   (PC_W),
    .NUM_BP (NUM_BP),
    .IDX_W  (IDX_W)
  ) u_bp_match (
    .pc_i       (pc),
    .bp_addr_i  (bp_addr_q),
    .bp_valid_i (bp_valid_q),
    .hit_o      (bp_hit),
    .idx_o      (bp_hit_idx)
  );

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    host_flag_d = host_flag_q;
    bp_idx_d    = bp_idx_q;
    cnt_d       = cnt_q;
    step_left_d = step_left_q;
    bp_addr_d   = bp_addr_q;
    bp_valid_d  = bp_valid_q;
    stop        = 1'b0;

    case (state_q)
      ST_HALTED: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_RUN:  state_d = ST_RUN;
            OP_STEP: begin
              state_d     = ST_STEP;
              step_left_d = (cmd_arg == '0) ? PC_W'(1) : cmd_arg;
            end
            OP_SET_BP: begin
              if (int'(cmd_idx) < NUM_BP) begin
                bp_addr_d[cmd_idx]  = cmd_arg;
                bp_valid_d[cmd_idx] = 1'b1;
              end
            end
            OP_CLR_BP: begin
              if (int'(cmd_idx) < NUM_BP) bp_valid_d[cmd_idx] = 1'b0;
            end
            default: ;
          endcase
        end
      end
      default: begin
        if (retire) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (state_q == ST_STEP) step_left_d = step_left_q - PC_W'(1);
          if (halt_instr) begin
            stop    = 1'b1;
            cause_d = CAUSE_HALT_INSTR;
          end else if (bp_hit) begin
            stop     = 1'b1;
            cause_d  = CAUSE_BREAK;
            bp_idx_d = bp_hit_idx;
          end else if ((state_q == ST_STEP) && (step_left_q <= PC_W'(1))) begin
            stop        = 1'b1;
            cause_d     = CAUSE_STEP_HOST;
            host_flag_d = 1'b0;
          end
        end
        // A retire-derived cause wins over a simultaneous host HALT.
        if (!stop && cmd_valid && (cmd_op == OP_HALT)) begin
          stop        = 1'b1;
          cause_d     = CAUSE_STEP_HOST;
          host_flag_d = 1'b1;
        end
        if (stop) state_d = ST_HALTED;
      end
    endcase

    cpu_en_d = (state_d != ST_HALTED);
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge CLK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state_q     <= ST_HALTED;
      cpu_en_q    <= 1'b0;
      halted_q    <= 1'b1;
      cause_q     <= CAUSE_RESET;
      host_flag_q <= 1'b0;
      bp_idx_q    <= '0;
      cnt_q       <= '0;
      step_left_q <= '0;
      bp_addr_q   <= '0;
      bp_valid_q  <= '0;
    end else begin
      state_q     <= state_d;
      cpu_en_q    <= cpu_en_d;
      halted_q    <= halted_d;
      cause_q     <= cause_d;
      host_flag_q <= host_flag_d;
      bp_idx_q    <= bp_idx_d;
      cnt_q       <= cnt_d;
      step_left_q <= step_left_d;
      bp_addr_q   <= bp_addr_d;
      bp_valid_q  <= bp_valid_d;
    end
  end

  assign cmd_ready   = 1'b1;
  assign cpu_en      = cpu_en_q;
  assign halted      = halted_q;
  assign cause       = cause_q;
  assign bp_idx      = bp_idx_q;
  assign retired_cnt = cnt_q;

endmodule
